// File: rtl/regfile_bank_pkg.sv
// Shared CPU constants for the integer register file: geometry, well-known
// register indices and reset values used by the storage and scoreboard.
package regfile_bank_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_AW    = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_SP   = 5'd2;

    localparam logic [XLEN-1:0]      REG_RESET_VALUE  = 32'h0000_0000;
    localparam logic [XLEN-1:0]      SP_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [REG_COUNT-1:0] BUSY_RESET       = '0;
    localparam logic [31:0]          WB_COUNT_RESET   = 32'h0000_0000;

endpackage

// File: rtl/regfile_bank_scoreboard.sv
// Pending-write scoreboard: tracks destinations claimed by deferred producers
// and reports decode hazards and claim acceptance from the registered state.
module regfile_scoreboard
    import regfile_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    input  logic [REG_AW-1:0]    wb_rd,
    input  logic                 issue_valid,
    input  logic [REG_AW-1:0]    issue_rd,
    input  logic [REG_AW-1:0]    rs1,
    input  logic [REG_AW-1:0]    rs2,
    output logic                 issue_ready,
    output logic                 stall,
    output logic [REG_COUNT-1:0] busy
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic                 claim_accept;

    // Ready and stall look only at busy_q, so a writeback landing this cycle
    // neither unblocks a claim nor drops a stall until the following cycle.
    always_comb begin
        issue_ready  = (issue_rd == REG_ZERO) || !busy_q[issue_rd];
        stall        = ((rs1 != REG_ZERO) && busy_q[rs1]) ||
                       ((rs2 != REG_ZERO) && busy_q[rs2]);
        claim_accept = issue_valid && issue_ready;

        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        // Applied after the clear so a same-register claim wins.
        if (claim_accept && (issue_rd != REG_ZERO)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= BUSY_RESET;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_bank.sv
// Integer register bank: 31 writable registers plus hard-wired x0, a commit
// counter and the pending-write scoreboard used by issue/decode.
module regfile_bank
    import regfile_bank_pkg::*;
#(
    parameter logic [XLEN-1:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    input  logic [REG_AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 issue_valid,
    input  logic [REG_AW-1:0]    issue_rd,
    output logic                 issue_ready,
    input  logic [REG_AW-1:0]    rs1,
    input  logic [REG_AW-1:0]    rs2,
    output logic                 stall,
    output logic [XLEN-1:0]      reg0,
    output logic [XLEN-1:0]      reg1,
    output logic [XLEN-1:0]      reg2,
    output logic [XLEN-1:0]      reg3,
    output logic [XLEN-1:0]      reg4,
    output logic [XLEN-1:0]      reg5,
    output logic [XLEN-1:0]      reg6,
    output logic [XLEN-1:0]      reg7,
    output logic [XLEN-1:0]      reg8,
    output logic [XLEN-1:0]      reg9,
    output logic [XLEN-1:0]      reg10,
    output logic [XLEN-1:0]      reg11,
    output logic [XLEN-1:0]      reg12,
    output logic [XLEN-1:0]      reg13,
    output logic [XLEN-1:0]      reg14,
    output logic [XLEN-1:0]      reg15,
    output logic [XLEN-1:0]      reg16,
    output logic [XLEN-1:0]      reg17,
    output logic [XLEN-1:0]      reg18,
    output logic [XLEN-1:0]      reg19,
    output logic [XLEN-1:0]      reg20,
    output logic [XLEN-1:0]      reg21,
    output logic [XLEN-1:0]      reg22,
    output logic [XLEN-1:0]      reg23,
    output logic [XLEN-1:0]      reg24,
    output logic [XLEN-1:0]      reg25,
    output logic [XLEN-1:0]      reg26,
    output logic [XLEN-1:0]      reg27,
    output logic [XLEN-1:0]      reg28,
    output logic [XLEN-1:0]      reg29,
    output logic [XLEN-1:0]      reg30,
    output logic [XLEN-1:0]      reg31,
    output logic [REG_COUNT-1:0] busy,
    output logic [31:0]          wb_count
);

    logic            wb_we;
    logic [XLEN-1:0] regs [REG_COUNT];
    logic [31:0]     wb_count_q;
    logic [31:0]     wb_count_d;

    assign wb_we   = wb_valid && (wb_rd != REG_ZERO);
    assign regs[0] = REG_RESET_VALUE;

    // Registers are plain flops rather than RAM: all 32 values are needed
    // in parallel by the read-port multiplexers.
    for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_reg
        localparam logic [XLEN-1:0] RESET_VAL =
            (REG_AW'(gi) == REG_SP) ? SP_RESET : REG_RESET_VALUE;

        logic [XLEN-1:0] reg_q;
        logic [XLEN-1:0] reg_d;

        always_comb begin
            reg_d = reg_q;
            if (wb_we && (wb_rd == REG_AW'(gi))) begin
                reg_d = wb_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                reg_q <= RESET_VAL;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign regs[gi] = reg_q;
    end

    always_comb begin
        wb_count_d = wb_count_q;
        if (wb_we) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_count_q <= WB_COUNT_RESET;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;

    regfile_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .issue_ready (issue_ready),
        .stall       (stall),
        .busy        (busy)
    );

    assign reg0  = regs[0];
    assign reg1  = regs[1];
    assign reg2  = regs[2];
    assign reg3  = regs[3];
    assign reg4  = regs[4];
    assign reg5  = regs[5];
    assign reg6  = regs[6];
    assign reg7  = regs[7];
    assign reg8  = regs[8];
    assign reg9  = regs[9];
    assign reg10 = regs[10];
    assign reg11 = regs[11];
    assign reg12 = regs[12];
    assign reg13 = regs[13];
    assign reg14 = regs[14];
    assign reg15 = regs[15];
    assign reg16 = regs[16];
    assign reg17 = regs[17];
    assign reg18 = regs[18];
    assign reg19 = regs[19];
    assign reg20 = regs[20];
    assign reg21 = regs[21];
    assign reg22 = regs[22];
    assign reg23 = regs[23];
    assign reg24 = regs[24];
    assign reg25 = regs[25];
    assign reg26 = regs[26];
    assign reg27 = regs[27];
    assign reg28 = regs[28];
    assign reg29 = regs[29];
    assign reg30 = regs[30];
    assign reg31 = regs[31];

endmodule
